mul_div_unit: RTL and testbench

//  Multi-cycle RV64M multiply/divide unit, parametrised in width. Covers MUL,

---
 rtl/mul_div_unit_if.sv | 15 +
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div unit.
interface mul_div_unit_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, x, y, input busy, done, result);
    modport slave  (input start, op, x, y, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle RV64M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle results for divide-by-zero and overflow.
module mul_div_unit #(
    parameter int XLEN = 64
) (
    input logic          clk,
    input logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic            neg_a_q, neg_a_d;
    logic            neg_r_q, neg_r_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            start_ok, last, fast, div_zero, div_ovf;
    logic            x_neg, y_neg;
    logic [XLEN-1:0] x_mag, y_mag, fast_res;
    logic [XLEN:0]   mul_sum, div_rs, div_diff;
    logic [2*XLEN-1:0] product, prod_s;
    logic [XLEN-1:0] quo, rem;
    logic            busy, done;

    // Request decode: acceptance, fast-path detection, operand magnitudes.
    always_comb begin
        start_ok = bus.start && (state_q != S_RUN);
        div_zero = bus.op[2] && (bus.y == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (bus.x == SMIN) && (bus.y == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) fast_res = bus.op[1] ? bus.x : '1;
        else          fast_res = bus.op[1] ? '0 : bus.x;
        x_neg = bus.x[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd2 ||
                                  bus.op == 3'd4 || bus.op == 3'd6);
        y_neg = bus.y[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6);
        x_mag = x_neg ? -bus.x : bus.x;
        y_mag = y_neg ? -bus.y : bus.y;
        last  = (cnt_q == CW'(XLEN-1));
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (last) state_d = S_FINISH;
            default: begin
                if (start_ok) state_d = fast ? S_FINISH : S_RUN;
                else          state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_FINISH);
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rs   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_rs - {1'b0, opnd_q};

        if (state_q == S_RUN) begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[2]) begin
                // A clear borrow bit means the divisor fits: keep the difference.
                hi_d = div_diff[XLEN] ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
                {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
            end
        end

        product = {hi_d, lo_d};
        prod_s  = neg_a_q ? -product : product;
        quo     = neg_a_q ? -lo_d : lo_d;
        rem     = neg_r_q ? -hi_d : hi_d;

        if (state_q == S_RUN && last) begin
            case (op_q)
                3'd0:                result_d = prod_s[XLEN-1:0];
                3'd1, 3'd2, 3'd3:    result_d = prod_s[2*XLEN-1:XLEN];
                3'd4, 3'd5:          result_d = quo;
                default:             result_d = rem;
            endcase
        end

        if (start_ok) begin
            cnt_d   = '0;
            op_d    = bus.op;
            hi_d    = '0;
            lo_d    = bus.op[2] ? x_mag : y_mag;
            opnd_d  = bus.op[2] ? y_mag : x_mag;
            neg_a_d = x_neg ^ y_neg;
            neg_r_d = x_neg;
            if (fast) result_d = fast_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: scoreboard of reference results plus latency checks.
module tb_mul_div_unit;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic reset;
    int   nvec;
    int   nfail;
    logic [63:0] sb[$];

    mul_div_unit_if #(.XLEN(64)) bus ();
    mul_div_unit #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] x,
                                              input logic [63:0] y);
        logic [127:0] sx, sy, ux, uy, p;
        logic [63:0] r;
        sx = {{64{x[63]}}, x};
        sy = {{64{y[63]}}, y};
        ux = {64'd0, x};
        uy = {64'd0, y};
        r  = '0;
        case (op)
            3'd0: begin p = ux * uy; r = p[63:0];   end
            3'd1: begin p = sx * sy; r = p[127:64]; end
            3'd2: begin p = sx * uy; r = p[127:64]; end
            3'd3: begin p = ux * uy; r = p[127:64]; end
            3'd4: begin
                if (y == 0) r = ONES;
                else if (x == SMIN && y == ONES) r = x;
                else r = $signed(x) / $signed(y);
            end
            3'd5: r = (y == 0) ? ONES : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == SMIN && y == ONES) r = '0;
                else r = $signed(x) % $signed(y);
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y);
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = x;
        bus.y     = y;
        sb.push_back(ref_model(op, x, y));
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.x     = {$urandom, $urandom};
        bus.y     = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int k0, output int lat, output int bc);
        int k;
        k  = k0;
        bc = 0;
        while (!bus.done && k < 300) begin
            if (bus.busy) bc++;
            @(negedge clk);
            k++;
        end
        lat = k;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [63:0] x,
                       input logic [63:0] y, input int exp_lat);
        int lat, bc;
        drive(op, x, y);
        wait_done(1, lat, bc);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(bc), 64'(exp_lat - 1));
    endtask

    // Scoreboard consumer: every DONE must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.done) begin
            chk("busy_with_done", 64'(bus.busy), 64'd0);
            if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else chk("result", bus.result, sb.pop_front());
        end
    end

    initial begin
        int lat, bc;
        logic [63:0] held;
        nvec = 0;
        nfail = 0;
        bus.start = 1'b0;
        bus.op = '0;
        bus.x = '0;
        bus.y = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run("mul", 3'd0, 64'd7, -64'sd3, 65);
        chk("mul_lit", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
        run("mulh", 3'd1, SMIN, SMIN, 65);
        chk("mulh_lit", bus.result, 64'h4000_0000_0000_0000);
        run("mulhu", 3'd3, SMIN, SMIN, 65);
        chk("mulhu_lit", bus.result, 64'h4000_0000_0000_0000);
        run("mulhsu", 3'd2, ONES, 64'd2, 65);
        chk("mulhsu_lit", bus.result, ONES);
        run("div", 3'd4, -64'sd7, 64'd2, 65);
        chk("div_lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem", 3'd6, -64'sd7, 64'd2, 65);
        chk("rem_lit", bus.result, ONES);
        run("divu", 3'd5, 64'd100, 64'd7, 65);
        chk("divu_lit", bus.result, 64'd14);
        run("remu", 3'd7, 64'd100, 64'd7, 65);
        chk("remu_lit", bus.result, 64'd2);
        run("rem_neg_y", 3'd6, 64'd7, -64'sd2, 65);
        run("mulh_mixed", 3'd1, -64'sd5, 64'h0123_4567_89AB_CDEF, 65);

        run("divu_z", 3'd5, 64'd5, 64'd0, 1);
        chk("divu_z_lit", bus.result, ONES);
        run("rem_z", 3'd6, 64'd5, 64'd0, 1);
        chk("rem_z_lit", bus.result, 64'd5);
        run("div_ovf", 3'd4, SMIN, ONES, 1);
        chk("div_ovf_lit", bus.result, SMIN);
        run("rem_ovf", 3'd6, SMIN, ONES, 1);
        run("div_z", 3'd4, -64'sd9, 64'd0, 1);

        held = bus.result;
        repeat (5) @(negedge clk);
        chk("result_held", bus.result, held);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] op;
            logic [63:0] x, y;
            op = 3'(i);
            x  = {$urandom, $urandom};
            y  = (i % 2 == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
            run("rand", op, x, y, 65);
        end

        // START while busy with different operands must be dropped.
        drive(3'd0, 64'd123456789, 64'd987654321);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.x     = 64'd1000;
        bus.y     = 64'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(11, lat, bc);
        chk("midrun_lat", 64'(lat), 64'd65);

        // Back-to-back: second START rides on the DONE cycle.
        drive(3'd7, 64'd1000, 64'd33);
        wait_done(1, lat, bc);
        chk("b2b_first_lat", 64'(lat), 64'd65);
        drive(3'd4, -64'sd1000, 64'd33);
        wait_done(1, lat, bc);
        chk("b2b_second_lat", 64'(lat), 64'd65);

        // Reset in the middle of a divide aborts it without a DONE.
        drive(3'd5, 64'hDEAD_BEEF_0000_1234, 64'd3);
        repeat (28) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_result", bus.result, 64'd0);
        sb.delete();
        repeat (70) @(negedge clk);
        run("after_abort", 3'd5, 64'd1000, 64'd7, 65);
        chk("after_abort_lit", bus.result, 64'd142);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
